branch_resolve_ctrl: RTL and testbench

// - Resolves branches for the pipelined LEGv8 CPU: B, CBZ, CBNZ, B.cond.
// - Owns the NZCV flags register. The Z flag comes from the 64-bit zero detector
//   (nor_64 instance) on the EX ALU result; the CBZ/CBNZ test uses a second nor_64
//   on the branch operand.
// - Sequences stall, redirect and flush: stalls while the operand is unresolved,

---
 rtl/branch_pkg.sv | 30 +++
 rtl/branch_resolve_ctrl_cond_eval.sv | 44 ++++
 rtl/nor_64.sv | 9 +
 rtl/branch_resolve_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for branch resolution: branch kinds, ARM condition codes,
// controller states and NZCV bit positions.
package branch_pkg;

    typedef enum logic [1:0] {
        B     = 2'd0,
        CBZ   = 2'd1,
        CBNZ  = 2'd2,
        BCOND = 2'd3
    } br_type_e;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, HS = 4'h2, LO = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/branch_resolve_ctrl_cond_eval.sv
// Combinational ARM condition-code evaluator over an NZCV flag vector.
module cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_taken
);

    cond_e w_cond;
    logic  w_n;
    logic  w_z;
    logic  w_c;
    logic  w_v;

    assign w_cond = cond_e'(i_cond);
    assign w_n    = i_nzcv[FLAG_N];
    assign w_z    = i_nzcv[FLAG_Z];
    assign w_c    = i_nzcv[FLAG_C];
    assign w_v    = i_nzcv[FLAG_V];

    always_comb begin
        o_taken = 1'b0;
        case (w_cond)
            EQ: o_taken = w_z;
            NE: o_taken = !w_z;
            HS: o_taken = w_c;
            LO: o_taken = !w_c;
            MI: o_taken = w_n;
            PL: o_taken = !w_n;
            VS: o_taken = w_v;
            VC: o_taken = !w_v;
            HI: o_taken = w_c && !w_z;
            LS: o_taken = !w_c || w_z;
            GE: o_taken = (w_n == w_v);
            LT: o_taken = (w_n != w_v);
            GT: o_taken = !w_z && (w_n == w_v);
            LE: o_taken = w_z || (w_n != w_v);
            AL: o_taken = 1'b1;
            NV: o_taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/nor_64.sv
// 64-bit zero detector: high when every input bit is zero.
module nor_64 (
    input  logic [63:0] i_data,
    output logic        o_zero
);

    assign o_zero = ~|i_data;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution for the pipelined LEGv8 core: owns NZCV, resolves B/CBZ/CBNZ/B.cond,
// and sequences stall, one-cycle redirect and a fixed-length IF/ID flush.
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MAX_WAIT     = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] alu_result,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        set_flags,
    input  logic        br_valid,
    input  logic [1:0]  br_type,
    input  logic [3:0]  br_cond,
    input  logic [63:0] br_operand,
    input  logic        operand_ready,
    input  logic [63:0] br_target,
    output logic        br_ready,
    output logic        stall_out,
    output logic        pc_sel,
    output logic [63:0] redirect_pc,
    output logic        flush,
    output logic [3:0]  flags_out,
    output logic        wait_timeout
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    state_e      r_state;
    state_e      w_state_next;
    logic [3:0]  r_flags;
    logic [3:0]  w_flags_next;
    logic        r_pc_sel;
    logic [63:0] r_redirect_pc;
    logic        r_flush;
    logic        r_wait_timeout;
    logic [2:0]  r_flush_cnt;
    logic [2:0]  w_flush_cnt_next;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_wait_cnt_next;
    logic        w_timeout_set;

    br_type_e    w_type;
    logic        w_alu_zero;
    logic        w_op_zero;
    logic        w_cond_taken;
    logic        w_taken;
    logic        w_needs_operand;
    logic        w_accept;

    nor_64 u_alu_zero (
        .i_data (alu_result),
        .o_zero (w_alu_zero)
    );

    nor_64 u_op_zero (
        .i_data (br_operand),
        .o_zero (w_op_zero)
    );

    // Flags loaded this cycle are forwarded to B.cond so a same-cycle SUBS is honoured.
    always_comb begin
        w_flags_next = r_flags;
        if (set_flags && !r_flush) begin
            w_flags_next[FLAG_N] = alu_result[63];
            w_flags_next[FLAG_Z] = w_alu_zero;
            w_flags_next[FLAG_C] = alu_carry;
            w_flags_next[FLAG_V] = alu_overflow;
        end
    end

    cond_eval u_cond_eval (
        .i_cond  (br_cond),
        .i_nzcv  (w_flags_next),
        .o_taken (w_cond_taken)
    );

    assign w_type          = br_type_e'(br_type);
    assign w_needs_operand = (w_type == CBZ) || (w_type == CBNZ);

    always_comb begin
        w_taken = 1'b0;
        case (w_type)
            B:     w_taken = 1'b1;
            CBZ:   w_taken = w_op_zero;
            CBNZ:  w_taken = !w_op_zero;
            BCOND: w_taken = w_cond_taken;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_flags        <= '0;
            r_pc_sel       <= 1'b0;
            r_redirect_pc  <= '0;
            r_flush        <= 1'b0;
            r_wait_timeout <= 1'b0;
            r_flush_cnt    <= '0;
            r_wait_cnt     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_flags     <= w_flags_next;
            r_pc_sel    <= w_accept && w_taken;
            r_flush     <= (w_state_next == FLUSH);
            r_flush_cnt <= w_flush_cnt_next;
            r_wait_cnt  <= w_wait_cnt_next;
            if (w_accept && w_taken) begin
                r_redirect_pc <= br_target;
            end
            if (w_timeout_set) begin
                r_wait_timeout <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        w_wait_cnt_next  = r_wait_cnt;
        w_timeout_set    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_taken) begin
                        w_state_next     = FLUSH;
                        w_flush_cnt_next = FLUSH_INIT;
                    end
                end else if (br_valid) begin
                    w_state_next    = WAIT;
                    w_wait_cnt_next = 4'd1;
                end
            end
            WAIT: begin
                if (w_accept) begin
                    w_wait_cnt_next = '0;
                    if (w_taken) begin
                        w_state_next     = FLUSH;
                        w_flush_cnt_next = FLUSH_INIT;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else if (!br_valid) begin
                    w_state_next    = IDLE;
                    w_wait_cnt_next = '0;
                end else if (r_wait_cnt == WAIT_LIMIT) begin
                    w_timeout_set = 1'b1;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 4'd1;
                end
            end
            FLUSH: begin
                if (r_flush_cnt <= 3'd1) begin
                    w_state_next     = IDLE;
                    w_flush_cnt_next = '0;
                end else begin
                    w_flush_cnt_next = r_flush_cnt - 3'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        w_accept = 1'b0;
        case (r_state)
            IDLE:    w_accept = br_valid && (!w_needs_operand || operand_ready);
            WAIT:    w_accept = br_valid && operand_ready;
            default: w_accept = 1'b0;
        endcase
    end

    assign br_ready     = w_accept;
    assign stall_out    = br_valid && !w_accept && !r_flush;
    assign pc_sel       = r_pc_sel;
    assign redirect_pc  = r_redirect_pc;
    assign flush        = r_flush;
    assign flags_out    = r_flags;
    assign wait_timeout = r_wait_timeout;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl; taken-branch targets are queued on accept and
// matched against each pc_sel pulse.
module tb_branch_resolve_ctrl;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] alu_result;
    logic        alu_carry;
    logic        alu_overflow;
    logic        set_flags;
    logic        br_valid;
    logic [1:0]  br_type;
    logic [3:0]  br_cond;
    logic [63:0] br_operand;
    logic        operand_ready;
    logic [63:0] br_target;
    logic        br_ready;
    logic        stall_out;
    logic        pc_sel;
    logic [63:0] redirect_pc;
    logic        flush;
    logic [3:0]  flags_out;
    logic        wait_timeout;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    branch_resolve_ctrl #(
        .FLUSH_CYCLES (2),
        .MAX_WAIT     (7)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_result    (alu_result),
        .alu_carry     (alu_carry),
        .alu_overflow  (alu_overflow),
        .set_flags     (set_flags),
        .br_valid      (br_valid),
        .br_type       (br_type),
        .br_cond       (br_cond),
        .br_operand    (br_operand),
        .operand_ready (operand_ready),
        .br_target     (br_target),
        .br_ready      (br_ready),
        .stall_out     (stall_out),
        .pc_sel        (pc_sel),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .flags_out     (flags_out),
        .wait_timeout  (wait_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    always @(negedge clk) begin
        if (pc_sel === 1'b1) begin
            if (exp_q.size() == 0) chk("redirect_unexpected", pc_sel, 0);
            else                   chk("redirect_pc", redirect_pc, exp_q.pop_front());
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic after_taken();
        nxt(); br_valid = 1'b0; set_flags = 1'b0;
        smp(); chk("flush_c1", flush, 1);
        nxt();
        smp(); chk("flush_c2", flush, 1); chk("pc_sel_c2", pc_sel, 0);
        nxt();
        smp(); chk("flush_c3", flush, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; alu_result = '0; alu_carry = 1'b0; alu_overflow = 1'b0;
        set_flags = 1'b0; br_valid = 1'b0; br_type = B; br_cond = '0;
        br_operand = '0; operand_ready = 1'b0; br_target = '0;
        nxt(); nxt();
        smp();
        chk("rst_flags", flags_out, 0); chk("rst_pc_sel", pc_sel, 0);
        chk("rst_redirect", redirect_pc, 0); chk("rst_flush", flush, 0);
        chk("rst_timeout", wait_timeout, 0); chk("rst_ready", br_ready, 0);
        chk("rst_stall", stall_out, 0);

        // Flags load
        nxt(); reset = 1'b0; set_flags = 1'b1; alu_result = '0; alu_carry = 1'b1;
        nxt(); alu_result = 64'h8000_0000_0000_0000; alu_carry = 1'b0;
        smp(); chk("flags_subs_zero", flags_out, 4'b0110);
        nxt(); set_flags = 1'b0;
        smp(); chk("flags_neg", flags_out, 4'b1000);

        // CBZ taken, operand ready
        nxt(); br_valid = 1'b1; br_type = CBZ; br_operand = '0; operand_ready = 1'b1;
        br_target = 64'h0000_0000_0040_0100;
        smp(); chk("cbz_ready", br_ready, 1); chk("cbz_stall", stall_out, 0);
        exp_q.push_back(br_target);
        after_taken();
        nxt(); br_valid = 1'b1; br_type = CBZ; br_operand = 64'd5; operand_ready = 1'b1;
        smp(); chk("cbz_nt_ready", br_ready, 1); chk("cbz_nt_stall", stall_out, 0);

        // CBNZ not taken, then back-to-back B
        nxt(); br_type = CBNZ; br_operand = '0;
        smp(); chk("cbnz_ready", br_ready, 1);
        nxt(); br_type = B; operand_ready = 1'b0; br_target = 64'h0000_0000_0040_0200;
        smp(); chk("b2b_ready", br_ready, 1); chk("b2b_stall", stall_out, 0);
        chk("cbnz_no_flush", flush, 0); chk("cbnz_no_pc_sel", pc_sel, 0);
        exp_q.push_back(br_target);
        after_taken();

        // CBZ with operand late by 3 cycles
        nxt(); br_valid = 1'b1; br_type = CBZ; br_operand = '0; operand_ready = 1'b0;
        br_target = 64'h0000_0000_0040_0300;
        for (int i = 0; i < 3; i++) begin
            smp(); chk("wait3_stall", stall_out, 1); chk("wait3_ready", br_ready, 0);
            nxt();
        end
        operand_ready = 1'b1;
        smp(); chk("wait3_accept", br_ready, 1); chk("wait3_stall_end", stall_out, 0);
        chk("wait3_timeout", wait_timeout, 0);
        exp_q.push_back(br_target);
        after_taken();

        // CBZ with operand late by 8 cycles: timeout appears after the 8th stalled edge
        nxt(); br_valid = 1'b1; br_type = CBZ; br_operand = '0; operand_ready = 1'b0;
        br_target = 64'h0000_0000_0040_0400;
        for (int i = 0; i < 8; i++) begin
            smp(); chk("wait8_stall", stall_out, 1); chk("wait8_timeout_low", wait_timeout, 0);
            nxt();
        end
        operand_ready = 1'b1;
        smp(); chk("wait8_timeout", wait_timeout, 1); chk("wait8_accept", br_ready, 1);
        exp_q.push_back(br_target);
        after_taken();

        // B.cond GT sees forwarded flags, not the registered Z=1
        nxt(); set_flags = 1'b1; alu_result = '0; alu_carry = 1'b0; alu_overflow = 1'b0;
        nxt(); alu_result = 64'd5; br_valid = 1'b1; br_type = BCOND; br_cond = GT;
        br_target = 64'h0000_0000_0040_0500;
        smp(); chk("gt_reg_flags", flags_out, 4'b0100); chk("gt_ready", br_ready, 1);
        exp_q.push_back(br_target);
        nxt(); br_cond = AL; br_target = 64'h0000_0000_0040_0600; alu_result = '0; alu_carry = 1'b1;
        smp(); chk("flush_bcond_ready", br_ready, 0); chk("flush_bcond_stall", stall_out, 0);
        chk("gt_flags", flags_out, 4'b0000); chk("gt_flush", flush, 1);
        nxt(); br_valid = 1'b0; set_flags = 1'b0;
        smp(); chk("flush_flags_hold", flags_out, 4'b0000); chk("flush_c2b", flush, 1);
        nxt();
        smp(); chk("flush_drop_end", flush, 0);
        nxt(); br_valid = 1'b1; br_type = BCOND; br_cond = EQ;
        smp(); chk("eq_nt_ready", br_ready, 1);
        nxt(); br_valid = 1'b0;
        smp(); chk("eq_nt_flush", flush, 0);

        // Condition sweep over forwarded flag patterns
        for (int c = 0; c < 16; c++) begin
            for (int r = 0; r < 3; r++) begin
                for (int cv = 0; cv < 4; cv++) begin
                    logic [3:0] nzcv;
                    nxt();
                    set_flags = 1'b1;
                    alu_result = (r == 0) ? 64'd0 : (r == 1) ? 64'h8000_0000_0000_0000 : 64'd5;
                    alu_carry = cv[1]; alu_overflow = cv[0];
                    br_valid = 1'b1; br_type = BCOND; br_cond = 4'(c);
                    br_target = 64'h1000 + 64'(c * 256 + r * 16 + cv);
                    nzcv = {r == 1, r == 0, cv[1], cv[0]};
                    smp(); chk("sweep_ready", br_ready, 1);
                    if (cond_model(4'(c), nzcv)) begin
                        exp_q.push_back(br_target);
                        after_taken();
                    end else begin
                        nxt(); br_valid = 1'b0; set_flags = 1'b0;
                        smp(); chk("sweep_nt_flush", flush, 0);
                    end
                    chk("sweep_flags", flags_out, nzcv);
                end
            end
        end

        // Reset while in WAIT
        nxt(); set_flags = 1'b1; alu_result = 64'h8000_0000_0000_0000; alu_carry = 1'b1;
        alu_overflow = 1'b1; br_valid = 1'b1; br_type = CBZ; br_operand = '0; operand_ready = 1'b0;
        smp(); chk("rw_stall_idle", stall_out, 1);
        nxt(); set_flags = 1'b0; reset = 1'b1;
        smp(); chk("rw_stall_wait", stall_out, 1); chk("rw_flags_pre", flags_out, 4'b1011);
        chk("rw_timeout_sticky", wait_timeout, 1);
        nxt(); reset = 1'b0; br_type = B; br_target = 64'h0000_0000_0040_0700;
        smp(); chk("rw_flags", flags_out, 0); chk("rw_pc_sel", pc_sel, 0);
        chk("rw_flush", flush, 0); chk("rw_redirect", redirect_pc, 0);
        chk("rw_timeout", wait_timeout, 0); chk("rw_idle_ready", br_ready, 1);
        exp_q.push_back(br_target);
        after_taken();

        // Reset in the first FLUSH cycle
        nxt(); br_valid = 1'b1; br_type = B; br_target = 64'h0000_0000_0040_0800;
        smp(); chk("rf_ready", br_ready, 1);
        exp_q.push_back(br_target);
        nxt(); br_valid = 1'b0; reset = 1'b1;
        smp(); chk("rf_flush_c1", flush, 1);
        nxt(); reset = 1'b0; br_valid = 1'b1; br_target = 64'h0000_0000_0040_0900;
        smp(); chk("rf_flush", flush, 0); chk("rf_pc_sel", pc_sel, 0);
        chk("rf_redirect", redirect_pc, 0); chk("rf_flags", flags_out, 0);
        chk("rf_idle_ready", br_ready, 1);
        exp_q.push_back(br_target);
        after_taken();

        nxt();
        smp(); chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
